data_mem_mmio: RTL and testbench

Data-side memory subsystem that sits directly downstream of the processor's MEM stage and consumes its `MemAddr`, `WriteData`, `MemWrite` and `MemRead` outputs. It returns `MemData` in the same cycle. The block contains a word-addressed data RAM and a small memory-mapped I/O page:

- GPIO output register
- 32-bit timer with compare flag
- UART transmitter with a transmit FIFO

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/fifo.sv | 49 ++++
 rtl/uart_tx.sv | 114 +++++++++++
 rtl/data_mem_mmio.sv | 105 ++++++++++
 tb/tb_data_mem_mmio.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO page addresses,
// STATUS bit positions, UART transmitter states and the address decoder.
// Latency: n/a (declarations only). Backpressure: n/a.
package dmem_pkg;

    // MMIO register byte addresses (only bits [15:2] take part in decode)
    localparam logic [15:0] GPIO_ADDR   = 16'h8000;
    localparam logic [15:0] TCOUNT_ADDR = 16'h8004;
    localparam logic [15:0] TCMP_ADDR   = 16'h8008;
    localparam logic [15:0] TXDATA_ADDR = 16'h800C;
    localparam logic [15:0] STATUS_ADDR = 16'h8010;

    // STATUS register bit indices
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_MATCH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // One-hot-or-zero target select; all zero means an unmapped MMIO address
    typedef struct packed {
        logic ram;
        logic gpio;
        logic tcount;
        logic tcmp;
        logic txdata;
        logic status;
    } dec_t;

    // Takes the word address MemAddr[15:2]; the MMIO page is fully decoded so
    // that e.g. 0x8020 does not alias onto GPIO.
    function automatic dec_t addr_decode(input logic [13:0] word_addr);
        dec_t d;
        d        = '0;
        d.ram    = ~word_addr[13];
        d.gpio   = (word_addr == GPIO_ADDR[15:2]);
        d.tcount = (word_addr == TCOUNT_ADDR[15:2]);
        d.tcmp   = (word_addr == TCMP_ADDR[15:2]);
        d.txdata = (word_addr == TXDATA_ADDR[15:2]);
        d.status = (word_addr == STATUS_ADDR[15:2]);
        return d;
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with extra-MSB pointers (DEPTH must be a power of two, >= 2).
// Latency: a pushed entry is visible at pop_dat one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//   Ports: Clock/Reset (sync, active-high); push_vld/push_dat in; pop_vld in, pop_dat out
//   (head entry, combinational); full/empty out (registered pointer state).
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop_vld && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign push_ok = push_vld && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers define which entries are valid
    always_ff @(posedge Clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter (LSB first, idle high) fed by a byte FIFO.
// Latency: push at edge N -> pop and start bit from edge N+1 when idle; frames back-to-back.
// Backpressure: none to the writer; pushes to a full FIFO are dropped.
//   Ports: Clock/Reset (sync, active-high); push_vld/push_dat in; full/empty/busy out
//   (registered state); TxD serial out.
module uart_tx
    import dmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       TxD
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    fifo_dat;
    logic          pop;
    logic          bit_end;
    logic          tx;

    fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .pop_dat  (fifo_dat),
        .full     (full),
        .empty    (empty)
    );

    assign bit_end = (cnt_q == BIT_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_dat;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = sh_q[0];
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                tx = 1'b1;
                // Chain straight into the next start bit so queued bytes leave gap-free
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_dat;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign TxD  = tx;
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory: word RAM plus MMIO page (GPIO, timer/compare, UART TX, STATUS).
// Latency: loads combinational (0 cycles); stores take effect at the clock edge.
// Backpressure: none; TXDATA writes to a full FIFO are dropped silently.
//   Ports: Clock/Reset (sync, active-high); MemAddr/WriteData/MemWrite/MemRead from MEM
//   stage; MemData load data (0 when MemRead low); GpioOut register; TxD UART line.
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS     = 1024,
    parameter int CLKS_PER_BIT  = 16,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] MemAddr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] MemData,
    output logic [7:0]  GpioOut,
    output logic        TxD
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    dec_t          dec;
    logic [7:0]    gpio_q;
    logic [31:0]   tcount_q;
    logic [31:0]   tcmp_q;
    logic          match_q;
    logic          match_clr;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_busy;
    logic [31:0]   status;
    logic [31:0]   rd_dat;
    logic          unused_addr_bits;

    // Word accesses only: the byte offset plays no part
    assign unused_addr_bits = ^MemAddr[1:0];

    // Upper RAM address bits are dropped, so the RAM aliases across 0x0000-0x7FFF
    assign ram_idx = MemAddr[AW+1:2];
    assign dec     = addr_decode(MemAddr[15:2]);

    always_ff @(posedge Clock) begin
        if (MemWrite && dec.ram) ram[ram_idx] <= WriteData;
    end

    assign match_clr = MemWrite && dec.status && WriteData[ST_MATCH];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            gpio_q   <= '0;
            tcount_q <= '0;
            tcmp_q   <= 32'hFFFF_FFFF;
            match_q  <= 1'b0;
        end else begin
            if (MemWrite && dec.gpio) gpio_q <= WriteData[7:0];
            if (MemWrite && dec.tcmp) tcmp_q <= WriteData;
            tcount_q <= (MemWrite && dec.tcount) ? WriteData : tcount_q + 32'd1;
            // A compare hit in the same cycle as a clear keeps the flag set
            match_q  <= (tcount_q == tcmp_q) || (match_q && !match_clr);
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (TX_FIFO_DEPTH)
    ) u_uart_tx (
        .Clock    (Clock),
        .Reset    (Reset),
        .push_vld (MemWrite && dec.txdata),
        .push_dat (WriteData[7:0]),
        .full     (tx_full),
        .empty    (tx_empty),
        .busy     (tx_busy),
        .TxD      (TxD)
    );

    always_comb begin
        status           = '0;
        status[ST_FULL]  = tx_full;
        status[ST_EMPTY] = tx_empty;
        status[ST_BUSY]  = tx_busy;
        status[ST_MATCH] = match_q;
    end

    // Reads see registered state, so a same-cycle write shows the old value
    always_comb begin
        rd_dat = '0;
        if (MemRead) begin
            if (dec.ram)         rd_dat = ram[ram_idx];
            else if (dec.gpio)   rd_dat = {24'd0, gpio_q};
            else if (dec.tcount) rd_dat = tcount_q;
            else if (dec.tcmp)   rd_dat = tcmp_q;
            else if (dec.status) rd_dat = status;
        end
    end

    assign MemData = rd_dat;
    assign GpioOut = gpio_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;
    localparam int CPB   = 4;
    localparam int RW    = 256;
    localparam int FD    = 4;
    localparam int FRAME = 10 * CPB;

    localparam logic [15:0] A_GPIO   = 16'h8000;
    localparam logic [15:0] A_TCOUNT = 16'h8004;
    localparam logic [15:0] A_TCMP   = 16'h8008;
    localparam logic [15:0] A_TXDATA = 16'h800C;
    localparam logic [15:0] A_STATUS = 16'h8010;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] MemAddr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemData;
    logic [7:0]  GpioOut;
    logic        TxD;

    int checks   = 0;
    int failures = 0;

    logic [7:0] txq [6];

    data_mem_mmio #(
        .RAM_WORDS     (RW),
        .CLKS_PER_BIT  (CPB),
        .TX_FIFO_DEPTH (FD)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .MemAddr   (MemAddr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .MemData   (MemData),
        .GpioOut   (GpioOut),
        .TxD       (TxD)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        MemAddr   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(posedge Clock);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        MemAddr  = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        #1;
        d        = MemData;
        MemRead  = 1'b0;
    endtask

    // Expected line level c cycles after the push edge; the first frame starts at c=1
    function automatic logic exp_txd(input int c, input int nfr);
        int j;
        int w;
        int bp;
        j = c - 1;
        if (j < 0 || j >= nfr * FRAME) return 1'b1;
        w  = j % FRAME;
        bp = w / CPB;
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return txq[j / FRAME][bp - 1];
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        Reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; MemAddr = '0; WriteData = '0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        checks++; if (GpioOut !== 8'h00) begin failures++; $display("FAIL reset_gpio: got %h expected 00", GpioOut); end
        checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", TxD); end
        rd(A_TCOUNT, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_tcount: got %h expected 00000000", v); end
        rd(A_TCMP, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_tcmp: got %h expected ffffffff", v); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL reset_status: got %h expected 00000002", v); end
        MemAddr = A_TCMP; MemRead = 1'b0; #1;
        checks++; if (MemData !== 32'h0) begin failures++; $display("FAIL read_idle_zero: got %h expected 00000000", MemData); end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(16'h0010, 32'hDEAD_BEEF);
        wr(16'h0014, 32'hCAFE_F00D);
        rd(16'h0010, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read: got %h expected deadbeef", v); end
        rd(16'h0010 + 16'(4 * RW), v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_alias: got %h expected deadbeef", v); end
        rd(16'h0014, v);
        checks++; if (v !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_second_word: got %h expected cafef00d", v); end
        MemAddr = 16'h0010; WriteData = 32'h1111_2222; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        checks++; if (MemData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rw_same_cycle: got %h expected deadbeef", MemData); end
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        rd(16'h0010, v);
        checks++; if (v !== 32'h1111_2222) begin failures++; $display("FAIL ram_rw_after: got %h expected 11112222", v); end
        rd(16'h0013, v);
        checks++; if (v !== 32'h1111_2222) begin failures++; $display("FAIL ram_byte_offset: got %h expected 11112222", v); end
    endtask

    task automatic test_gpio_unmapped();
        logic [31:0] v;
        wr(A_GPIO, 32'h1234_56A5);
        checks++; if (GpioOut !== 8'hA5) begin failures++; $display("FAIL gpio_out: got %h expected a5", GpioOut); end
        rd(A_GPIO, v);
        checks++; if (v !== 32'h0000_00A5) begin failures++; $display("FAIL gpio_read: got %h expected 000000a5", v); end
        rd(16'h8020, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h expected 00000000", v); end
        wr(16'h8020, 32'hFFFF_FFFF);
        checks++; if (GpioOut !== 8'hA5) begin failures++; $display("FAIL unmapped_write_gpio: got %h expected a5", GpioOut); end
        rd(16'h8020, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_read_after: got %h expected 00000000", v); end
        rd(A_TCMP, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL unmapped_write_tcmp: got %h expected ffffffff", v); end
        rd(A_TXDATA, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h expected 00000000", v); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL unmapped_status: got %h expected 00000002", v); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        wr(A_TCMP, 32'h0000_0001);
        wr(A_TCOUNT, 32'hFFFF_FFFE);
        rd(A_TCOUNT, v);
        checks++; if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL tcount_load: got %h expected fffffffe", v); end
        tick();
        rd(A_TCOUNT, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL tcount_inc: got %h expected ffffffff", v); end
        tick();
        rd(A_TCOUNT, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL tcount_wrap: got %h expected 00000000", v); end
        rd(A_STATUS, v);
        checks++; if (v[3] !== 1'b0) begin failures++; $display("FAIL match_early: got %b expected 0", v[3]); end
        tick();
        rd(A_TCOUNT, v);
        checks++; if (v !== 32'h1) begin failures++; $display("FAIL tcount_eq: got %h expected 00000001", v); end
        tick();
        rd(A_STATUS, v);
        checks++; if (v[3] !== 1'b1) begin failures++; $display("FAIL match_set: got %b expected 1", v[3]); end
        wr(A_STATUS, 32'h0000_0008);
        rd(A_STATUS, v);
        checks++; if (v[3] !== 1'b0) begin failures++; $display("FAIL match_clear: got %b expected 0", v[3]); end
        wr(A_TCMP, 32'h0000_0200);
        wr(A_TCOUNT, 32'h0000_01FF);
        tick();
        rd(A_STATUS, v);
        checks++; if (v[3] !== 1'b0) begin failures++; $display("FAIL match_pre_coincide: got %b expected 0", v[3]); end
        wr(A_STATUS, 32'h0000_0008);
        rd(A_STATUS, v);
        checks++; if (v[3] !== 1'b1) begin failures++; $display("FAIL match_set_wins: got %b expected 1", v[3]); end
        tick();
        rd(A_STATUS, v);
        checks++; if (v[3] !== 1'b1) begin failures++; $display("FAIL match_sticky: got %b expected 1", v[3]); end
        wr(A_STATUS, 32'h0000_0008);
        rd(A_STATUS, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL timer_status_final: got %h expected 00000002", v); end
    endtask

    task automatic test_uart_single();
        logic [31:0] v;
        logic        eb;
        txq[0] = 8'h55;
        MemAddr = A_TXDATA; WriteData = 32'h0000_0055; MemWrite = 1'b1; MemRead = 1'b0;
        for (int c = 0; c <= FRAME + 6; c++) begin
            @(posedge Clock);
            #1;
            MemWrite = 1'b0;
            checks++;
            if (TxD !== exp_txd(c, 1)) begin
                failures++; $display("FAIL uart1_txd c=%0d: got %b expected %b", c, TxD, exp_txd(c, 1));
            end
            rd(A_STATUS, v);
            eb = (c >= 1 && c <= FRAME);
            checks++;
            if (v[2] !== eb) begin failures++; $display("FAIL uart1_busy c=%0d: got %b expected %b", c, v[2], eb); end
            if (c == 0) begin
                checks++;
                if (v !== 32'h0) begin failures++; $display("FAIL uart1_status_push: got %h expected 00000000", v); end
            end
        end
    endtask

    task automatic test_fifo_boundary();
        logic [31:0] v;
        logic [31:0] es;
        txq[0] = 8'hA1; txq[1] = 8'h3C; txq[2] = 8'h5A;
        txq[3] = 8'h0F; txq[4] = 8'hF0; txq[5] = 8'h99;
        for (int c = 0; c < 5 * FRAME + 10; c++) begin
            if (c < 6) begin
                MemAddr = A_TXDATA; WriteData = {24'd0, txq[c]}; MemWrite = 1'b1; MemRead = 1'b0;
            end
            @(posedge Clock);
            #1;
            MemWrite = 1'b0;
            checks++;
            if (TxD !== exp_txd(c, 5)) begin
                failures++; $display("FAIL fifo_txd c=%0d: got %b expected %b", c, TxD, exp_txd(c, 5));
            end
            if (c == 4 || c == 5 || c == 160 || c == 161 || c == 200 || c == 201) begin
                case (c)
                    4, 5:    es = 32'h5;
                    160:     es = 32'h4;
                    161,200: es = 32'h6;
                    default: es = 32'h2;
                endcase
                rd(A_STATUS, v);
                checks++;
                if (v !== es) begin failures++; $display("FAIL fifo_status c=%0d: got %h expected %h", c, v, es); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        wr(A_GPIO, 32'h0000_003C);
        wr(A_TXDATA, 32'h0000_0081);
        wr(A_TXDATA, 32'h0000_007E);
        repeat (10) tick();
        rd(A_STATUS, v);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL midframe_status_pre: got %h expected 00000004", v); end
        Reset = 1'b1;
        tick();
        checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL midframe_txd: got %b expected 1", TxD); end
        checks++; if (GpioOut !== 8'h00) begin failures++; $display("FAIL midframe_gpio: got %h expected 00", GpioOut); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL midframe_status: got %h expected 00000002", v); end
        rd(A_TCOUNT, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL midframe_tcount: got %h expected 00000000", v); end
        Reset = 1'b0;
        for (int c = 0; c < FRAME + 10; c++) begin
            tick();
            checks++;
            if (TxD !== 1'b1) begin failures++; $display("FAIL midframe_idle c=%0d: got %b expected 1", c, TxD); end
        end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL midframe_status_end: got %h expected 00000002", v); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio_unmapped();
        test_timer();
        test_uart_single();
        test_fifo_boundary();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
